fp_addsub_sequencer: RTL and testbench

//  Multi-cycle controller for the FPU add/sub significand path. Swaps operands,

---
 rtl/fp_addsub_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_fp_addsub_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle add/sub significand controller: swap, align with round, add/sub, normalise.
// Build option FPSEQ_LZC_EN: single-cycle leading-zero normalisation instead of one shift per cycle.
module fp_addsub_sequencer #(
    parameter int SIG_W = 24,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [SIG_W-1:0] a_sig,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [SIG_W-1:0] b_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] res_exp,
    output logic [SIG_W-1:0] res_sig,
    output logic             res_swap,
    output logic             res_ovf
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    localparam logic [SIG_W-1:0] SIG_MSB  = {1'b1, {(SIG_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] SIG_W_E  = EXP_W'(SIG_W);
    localparam logic [EXP_W:0]   EXP_SAT  = {1'b0, {EXP_W{1'b1}}};

    state_t             state_q, state_d;
    logic               sub_q, sub_d;
    logic [EXP_W-1:0]   a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [SIG_W-1:0]   a_sig_q, a_sig_d, b_sig_q, b_sig_d;
    logic               swap_q, swap_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [SIG_W-1:0]   aln_q, aln_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [EXP_W-1:0]   res_exp_q, res_exp_d;
    logic [SIG_W-1:0]   res_sig_q, res_sig_d;
    logic               res_swap_q, res_swap_d;
    logic               res_ovf_q, res_ovf_d;

    logic               swap_c;
    logic [EXP_W-1:0]   big_exp_c, small_exp_c, shamt_c;
    logic [SIG_W-1:0]   big_sig_c, small_sig_c, shifted_c, rnd_vec_c, aligned_c;
    logic [SIG_W:0]     sum_c, rnd_c;
    logic [EXP_W:0]     exp_ext_c;
    logic [SIG_W-1:0]   add_sig_c;

    // Alignment datapath
    always_comb begin
        swap_c      = (b_exp_q > a_exp_q) || ((b_exp_q == a_exp_q) && (b_sig_q > a_sig_q));
        big_exp_c   = swap_c ? b_exp_q : a_exp_q;
        small_exp_c = swap_c ? a_exp_q : b_exp_q;
        big_sig_c   = swap_c ? b_sig_q : a_sig_q;
        small_sig_c = swap_c ? a_sig_q : b_sig_q;
        shamt_c     = big_exp_c - small_exp_c;
        shifted_c   = small_sig_c >> shamt_c;
        rnd_vec_c   = small_sig_c >> (shamt_c - EXP_W'(1));
        if (shamt_c == '0)
            aligned_c = small_sig_c;
        else if (shamt_c > SIG_W_E)
            aligned_c = '0;
        else
            aligned_c = shifted_c + SIG_W'(rnd_vec_c[0]);
    end

    // Add/subtract datapath; carry-out is folded back with round-on-last-bit-out
    always_comb begin
        sum_c     = sub_q ? ({1'b0, sig_q} - {1'b0, aln_q}) : ({1'b0, sig_q} + {1'b0, aln_q});
        rnd_c     = {1'b0, sum_c[SIG_W:1]} + (SIG_W+1)'(sum_c[0]);
        exp_ext_c = {1'b0, exp_q};
        add_sig_c = sum_c[SIG_W-1:0];
        if (!sub_q && sum_c[SIG_W]) begin
            if (rnd_c[SIG_W]) begin
                add_sig_c = SIG_MSB;
                exp_ext_c = {1'b0, exp_q} + (EXP_W+1)'(2);
            end else begin
                add_sig_c = rnd_c[SIG_W-1:0];
                exp_ext_c = {1'b0, exp_q} + (EXP_W+1)'(1);
            end
        end
    end

`ifdef FPSEQ_LZC_EN
    logic [EXP_W-1:0] lz_c, exp_lim_c, nsh_c;

    // Shift is clamped so the exponent never drops below 1, matching the iterative path
    always_comb begin
        lz_c = SIG_W_E;
        for (int i = 0; i < SIG_W; i++)
            if (sig_q[i]) lz_c = EXP_W'(SIG_W - 1 - i);
        exp_lim_c = (exp_q == '0) ? '0 : (exp_q - EXP_W'(1));
        nsh_c     = (lz_c < exp_lim_c) ? lz_c : exp_lim_c;
    end
`endif

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        a_exp_d     = a_exp_q;
        a_sig_d     = a_sig_q;
        b_exp_d     = b_exp_q;
        b_sig_d     = b_sig_q;
        swap_d      = swap_q;
        exp_d       = exp_q;
        sig_d       = sig_q;
        aln_d       = aln_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        res_exp_d   = res_exp_q;
        res_sig_d   = res_sig_q;
        res_swap_d  = res_swap_q;
        res_ovf_d   = res_ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sub_d   = op_sub;
                    a_exp_d = a_exp;
                    a_sig_d = a_sig;
                    b_exp_d = b_exp;
                    b_sig_d = b_sig;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                swap_d  = swap_c;
                exp_d   = big_exp_c;
                sig_d   = big_sig_c;
                aln_d   = aligned_c;
                ovf_d   = 1'b0;
                state_d = S_ADD;
            end
            S_ADD: begin
                if (exp_ext_c >= EXP_SAT) begin
                    ovf_d = 1'b1;
                    exp_d = '1;
                    sig_d = '0;
                end else begin
                    exp_d = exp_ext_c[EXP_W-1:0];
                    sig_d = add_sig_c;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (ovf_q) begin
                    state_d = S_DONE;
                end else if (sig_q == '0) begin
                    exp_d   = '0;
                    state_d = S_DONE;
                end else begin
`ifdef FPSEQ_LZC_EN
                    sig_d   = sig_q << nsh_c;
                    exp_d   = exp_q - nsh_c;
                    state_d = S_DONE;
`else
                    if (sig_q[SIG_W-1] || (exp_q <= EXP_W'(1))) begin
                        state_d = S_DONE;
                    end else begin
                        sig_d = sig_q << 1;
                        exp_d = exp_q - EXP_W'(1);
                    end
`endif
                end
            end
            S_DONE: begin
                // First DONE cycle latches the result; it then holds until taken
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    res_exp_d   = exp_q;
                    res_sig_d   = sig_q;
                    res_swap_d  = swap_q;
                    res_ovf_d   = ovf_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sub_q       <= 1'b0;
            a_exp_q     <= '0;
            a_sig_q     <= '0;
            b_exp_q     <= '0;
            b_sig_q     <= '0;
            swap_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            aln_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            res_exp_q   <= '0;
            res_sig_q   <= '0;
            res_swap_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            a_exp_q     <= a_exp_d;
            a_sig_q     <= a_sig_d;
            b_exp_q     <= b_exp_d;
            b_sig_q     <= b_sig_d;
            swap_q      <= swap_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            aln_q       <= aln_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            res_exp_q   <= res_exp_d;
            res_sig_q   <= res_sig_d;
            res_swap_q  <= res_swap_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign res_exp   = res_exp_q;
    assign res_sig   = res_sig_q;
    assign res_swap  = res_swap_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed vector bench for fp_addsub_sequencer; latency expectation follows FPSEQ_LZC_EN.
module tb_fp_addsub_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_sig, b_sig;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  res_exp;
    logic [23:0] res_sig;
    logic        res_swap;
    logic        res_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        op;
        logic [7:0]  ae;
        logic [23:0] as;
        logic [7:0]  be;
        logic [23:0] bs;
        logic [7:0]  ee;
        logic [23:0] es;
        logic        esw;
        logic        eov;
        int          shifts;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    fp_addsub_sequencer #(.SIG_W(24), .EXP_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a_exp     (a_exp),
        .a_sig     (a_sig),
        .b_exp     (b_exp),
        .b_sig     (b_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_exp   (res_exp),
        .res_sig   (res_sig),
        .res_swap  (res_swap),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input int shifts);
`ifdef FPSEQ_LZC_EN
        return 4;
`else
        return 4 + shifts;
`endif
    endfunction

    task automatic start_op(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        op_sub   = v.op;
        a_exp    = v.ae;
        a_sig    = v.as;
        b_exp    = v.be;
        b_sig    = v.bs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input int hold);
        vec_t v;
        int lat;
        v = vecs[idx];
        chk($sformatf("v%0d in_ready idle", idx), 32'(in_ready), 32'd1);
        start_op(v);
        chk($sformatf("v%0d in_ready busy", idx), 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_latency(v.shifts)));
        chk($sformatf("v%0d res_exp", idx), 32'(res_exp), 32'(v.ee));
        chk($sformatf("v%0d res_sig", idx), 32'(res_sig), 32'(v.es));
        chk($sformatf("v%0d res_swap", idx), 32'(res_swap), 32'(v.esw));
        chk($sformatf("v%0d res_ovf", idx), 32'(res_ovf), 32'(v.eov));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d hold%0d valid", idx, h), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d hold%0d in_ready", idx, h), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d hold%0d exp", idx, h), 32'(res_exp), 32'(v.ee));
            chk($sformatf("v%0d hold%0d sig", idx, h), 32'(res_sig), 32'(v.es));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d valid drop", idx), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d back idle", idx), 32'(in_ready), 32'd1);
    endtask

    initial begin
        //        op    ae     as          be     bs          ee     es          sw  ov  shifts
        vecs[0]  = '{1'b0, 8'h80, 24'h800000, 8'h80, 24'h800000, 8'h81, 24'h800000, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 8'h7F, 24'h800000, 8'h80, 24'hC00000, 8'h81, 24'h800000, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b1, 8'h80, 24'h800001, 8'h80, 24'h800000, 8'h69, 24'h800000, 1'b0, 1'b0, 23};
        vecs[3]  = '{1'b1, 8'h80, 24'h800000, 8'h80, 24'h800000, 8'h00, 24'h000000, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 8'hFE, 24'hFFFFFF, 8'hFE, 24'hFFFFFF, 8'hFF, 24'h000000, 1'b0, 1'b1, 0};
        vecs[5]  = '{1'b0, 8'h82, 24'h800000, 8'h80, 24'h800003, 8'h82, 24'hA00001, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 8'h90, 24'h800000, 8'h70, 24'hFFFFFF, 8'h90, 24'h800000, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 8'h98, 24'h800000, 8'h80, 24'h800000, 8'h98, 24'h800001, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 8'h80, 24'hFFFFFF, 8'h80, 24'h800000, 8'h81, 24'hC00000, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 8'h80, 24'h800000, 8'h80, 24'h900000, 8'h7D, 24'h800000, 1'b1, 1'b0, 3};
        vecs[10] = '{1'b1, 8'h02, 24'h800001, 8'h02, 24'h800000, 8'h01, 24'h000002, 1'b0, 1'b0, 1};
        vecs[11] = '{1'b1, 8'h00, 24'h400000, 8'h00, 24'h100000, 8'h00, 24'h300000, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b1, 8'h7E, 24'h800000, 8'h80, 24'h800000, 8'h7F, 24'hC00000, 1'b1, 1'b0, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_sub    = 1'b0;
        a_exp     = '0;
        a_sig     = '0;
        b_exp     = '0;
        b_sig     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset res_exp", 32'(res_exp), 32'd0);
        chk("reset res_sig", 32'(res_sig), 32'd0);
        chk("reset res_swap", 32'(res_swap), 32'd0);
        chk("reset res_ovf", 32'(res_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            run_vec(i, 0);

        // Abort a long normalisation with reset
        start_op(vecs[2]);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort res_sig", 32'(res_sig), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort stays idle", 32'(out_valid), 32'd0);

        // Back-pressure in DONE
        run_vec(1, 5);
        run_vec(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
